// File: rtl/int_request_ctl.sv
// Interrupt request controller: NMI/INT arbitration at instruction boundaries, IFF1/IFF2 and IM.
// Optional NMI_GLITCH_FILTER_EN: an NMI edge needs two consecutive high samples after a low one.
module int_request_ctl (
    input  logic       clk,
    input  logic       nreset,
    input  logic       nmi,
    input  logic       intr,
    input  logic       T_last,
    input  logic       instr_end,
    input  logic       ctl_ei,
    input  logic       ctl_di,
    input  logic       ctl_retn,
    input  logic       ctl_im_we,
    input  logic [1:0] im_in,
    input  logic       ack,
    input  logic       svc_done,
    output logic       nmi_req,
    output logic       int_req,
    output logic       in_nmi,
    output logic       in_int,
    output logic       iff1,
    output logic       iff2,
    output logic [1:0] im
);

    typedef enum logic [2:0] {
        StIdle,
        StNmiPend,
        StIntPend,
        StNmiSvc,
        StIntSvc
    } state_e;

    state_e state;
    logic   nmi_q;
    logic   nmi_latch;
    logic   ei_shadow;
    logic   nmi_rise;
    logic   boundary;
    logic   nmi_ack;
    logic   int_ack;

`ifdef NMI_GLITCH_FILTER_EN
    logic nmi_qq;
    assign nmi_rise = nmi && nmi_q && !nmi_qq;
`else
    assign nmi_rise = nmi && !nmi_q;
`endif

    assign boundary = T_last && instr_end;
    assign nmi_ack  = (state == StNmiPend) && ack;
    assign int_ack  = (state == StIntPend) && ack;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state     <= StIdle;
            nmi_req   <= 1'b0;
            int_req   <= 1'b0;
            in_nmi    <= 1'b0;
            in_int    <= 1'b0;
            iff1      <= 1'b0;
            iff2      <= 1'b0;
            im        <= 2'd0;
            nmi_q     <= 1'b0;
            nmi_latch <= 1'b0;
            ei_shadow <= 1'b0;
`ifdef NMI_GLITCH_FILTER_EN
            nmi_qq    <= 1'b0;
`endif
        end else begin
            nmi_q <= nmi;
`ifdef NMI_GLITCH_FILTER_EN
            nmi_qq <= nmi_q;
`endif
            // Edges arriving while latched are absorbed; the ack consumes the latch.
            if (nmi_ack) begin
                nmi_latch <= 1'b0;
            end else if (nmi_rise) begin
                nmi_latch <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (boundary && nmi_latch) begin
                        state   <= StNmiPend;
                        nmi_req <= 1'b1;
                    end else if (boundary && intr && iff1 && !ei_shadow) begin
                        state   <= StIntPend;
                        int_req <= 1'b1;
                    end
                end
                StNmiPend: begin
                    if (ack) begin
                        state   <= StNmiSvc;
                        nmi_req <= 1'b0;
                        in_nmi  <= 1'b1;
                    end
                end
                StIntPend: begin
                    if (ack) begin
                        state   <= StIntSvc;
                        int_req <= 1'b0;
                        in_int  <= 1'b1;
                    end
                end
                StNmiSvc, StIntSvc: begin
                    if (svc_done) begin
                        state  <= StIdle;
                        in_nmi <= 1'b0;
                        in_int <= 1'b0;
                    end
                end
                default: begin
                    state   <= StIdle;
                    nmi_req <= 1'b0;
                    int_req <= 1'b0;
                    in_nmi  <= 1'b0;
                    in_int  <= 1'b0;
                end
            endcase

            // IFF strobe priority: ack > DI > EI > RETN.
            if (nmi_ack) begin
                iff1 <= 1'b0;
            end else if (int_ack) begin
                iff1 <= 1'b0;
                iff2 <= 1'b0;
            end else if (ctl_di) begin
                iff1 <= 1'b0;
                iff2 <= 1'b0;
            end else if (ctl_ei) begin
                iff1 <= 1'b1;
                iff2 <= 1'b1;
            end else if (ctl_retn) begin
                iff1 <= iff2;
            end

            // Shadow hides INT from exactly one boundary after EI.
            if (ctl_di) begin
                ei_shadow <= 1'b0;
            end else if (ctl_ei) begin
                ei_shadow <= 1'b1;
            end else if (boundary) begin
                ei_shadow <= 1'b0;
            end

            if (ctl_im_we) begin
                im <= (im_in == 2'd3) ? 2'd2 : im_in;
            end
        end
    end

endmodule

// File: tb/tb_int_request_ctl.sv
// Bench for int_request_ctl: directed scenarios with constant expectations plus a random run
// checked against a rule-level model of the controller.
module tb_int_request_ctl;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       nmi = 1'b0, intr = 1'b0, T_last = 1'b0, instr_end = 1'b0;
    logic       ctl_ei = 1'b0, ctl_di = 1'b0, ctl_retn = 1'b0, ctl_im_we = 1'b0;
    logic [1:0] im_in = 2'd0;
    logic       ack = 1'b0, svc_done = 1'b0;
    logic       nmi_req, int_req, in_nmi, in_int, iff1, iff2;
    logic [1:0] im;

    int checks = 0;
    int errors = 0;

    int_request_ctl dut (
        .clk       (clk),
        .nreset    (nreset),
        .nmi       (nmi),
        .intr      (intr),
        .T_last    (T_last),
        .instr_end (instr_end),
        .ctl_ei    (ctl_ei),
        .ctl_di    (ctl_di),
        .ctl_retn  (ctl_retn),
        .ctl_im_we (ctl_im_we),
        .im_in     (im_in),
        .ack       (ack),
        .svc_done  (svc_done),
        .nmi_req   (nmi_req),
        .int_req   (int_req),
        .in_nmi    (in_nmi),
        .in_int    (in_int),
        .iff1      (iff1),
        .iff2      (iff2),
        .im        (im)
    );

    always #5 clk = ~clk;

    // Observed vector: {nmi_req, int_req, in_nmi, in_int, iff1, iff2, im}
    wire [7:0] obs = {nmi_req, int_req, in_nmi, in_int, iff1, iff2, im};

    // Reference model. phase: 0 idle, 1 NMI pending, 2 INT pending, 3 NMI service, 4 INT service.
    int       m_phase = 0;
    bit       m_iff1 = 0, m_iff2 = 0, m_latch = 0, m_shadow = 0;
    bit [1:0] m_im = 0;
    bit       m_hist [2] = '{0, 0};  // previous NMI pin samples, newest first

    task automatic model_update();
        bit rise, bnd, took_nmi, took_int;
        if (!nreset) begin
            m_phase = 0; m_iff1 = 0; m_iff2 = 0; m_latch = 0; m_shadow = 0; m_im = 0;
            m_hist[0] = 0; m_hist[1] = 0;
            return;
        end
        bnd = T_last && instr_end;
`ifdef NMI_GLITCH_FILTER_EN
        rise = nmi && m_hist[0] && !m_hist[1];
`else
        rise = nmi && !m_hist[0];
`endif
        took_nmi = (m_phase == 1) && ack;
        took_int = (m_phase == 2) && ack;
        if (m_phase == 0 && bnd) begin
            if (m_latch) m_phase = 1;
            else if (intr && m_iff1 && !m_shadow) m_phase = 2;
        end else if ((m_phase == 1 || m_phase == 2) && ack) begin
            m_phase = m_phase + 2;
        end else if ((m_phase == 3 || m_phase == 4) && svc_done) begin
            m_phase = 0;
        end
        if (took_nmi) m_latch = 0;
        else if (rise) m_latch = 1;
        if (took_nmi) m_iff1 = 0;
        else if (took_int || ctl_di) begin m_iff1 = 0; m_iff2 = 0; end
        else if (ctl_ei) begin m_iff1 = 1; m_iff2 = 1; end
        else if (ctl_retn) m_iff1 = m_iff2;
        if (ctl_di) m_shadow = 0;
        else if (ctl_ei) m_shadow = 1;
        else if (bnd) m_shadow = 0;
        if (ctl_im_we) m_im = (im_in == 2'd3) ? 2'd2 : im_in;
        m_hist[1] = m_hist[0];
        m_hist[0] = nmi;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic bnd_tick();
        T_last = 1; instr_end = 1; tick(); T_last = 0; instr_end = 0;
    endtask
    task automatic pulse_ack();  ack = 1;      tick(); ack = 0;      endtask
    task automatic pulse_done(); svc_done = 1; tick(); svc_done = 0; endtask
    task automatic pulse_ei();   ctl_ei = 1;   tick(); ctl_ei = 0;   endtask
    task automatic pulse_di();   ctl_di = 1;   tick(); ctl_di = 0;   endtask
    task automatic pulse_retn(); ctl_retn = 1; tick(); ctl_retn = 0; endtask
    task automatic nmi_pulse(input int n);
        nmi = 1; repeat (n) tick(); nmi = 0; tick();
    endtask

    task automatic test_reset();
        nreset = 0; nmi = 1; intr = 1;
        repeat (3) tick();
        checks++;
        if (obs !== 8'b0000_0000) begin
            errors++; $display("FAIL reset_hold: got %b want %b", obs, 8'b0000_0000);
        end
        nmi = 0; nreset = 1;
        repeat (3) tick();
        checks++;
        if (obs !== 8'b0000_0000) begin
            errors++; $display("FAIL reset_release: got %b want %b", obs, 8'b0000_0000);
        end
        intr = 0;
    endtask

    task automatic test_ei_int();
        intr = 1;
        pulse_ei();
        checks++;
        if (obs !== 8'b0000_1100) begin
            errors++; $display("FAIL ei_sets_iff: got %b want %b", obs, 8'b0000_1100);
        end
        tick(); bnd_tick();
        checks++;
        if (obs !== 8'b0000_1100) begin
            errors++; $display("FAIL ei_shadow: got %b want %b", obs, 8'b0000_1100);
        end
        tick(); bnd_tick();
        checks++;
        if (obs !== 8'b0100_1100) begin
            errors++; $display("FAIL int_req: got %b want %b", obs, 8'b0100_1100);
        end
        intr = 0; tick();
        checks++;
        if (obs !== 8'b0100_1100) begin
            errors++; $display("FAIL int_req_held: got %b want %b", obs, 8'b0100_1100);
        end
        pulse_ack();
        checks++;
        if (obs !== 8'b0001_0000) begin
            errors++; $display("FAIL int_ack: got %b want %b", obs, 8'b0001_0000);
        end
        pulse_done();
        checks++;
        if (obs !== 8'b0000_0000) begin
            errors++; $display("FAIL int_done: got %b want %b", obs, 8'b0000_0000);
        end
    endtask

    task automatic test_nmi_di();
        pulse_di(); nmi_pulse(2); bnd_tick();
        checks++;
        if (obs !== 8'b1000_0000) begin
            errors++; $display("FAIL nmi_req_di: got %b want %b", obs, 8'b1000_0000);
        end
        pulse_ack();
        checks++;
        if (obs !== 8'b0010_0000) begin
            errors++; $display("FAIL nmi_ack_di: got %b want %b", obs, 8'b0010_0000);
        end
        pulse_done();
        pulse_ei(); nmi_pulse(2); bnd_tick();
        checks++;
        if (obs !== 8'b1000_1100) begin
            errors++; $display("FAIL nmi_req_ei: got %b want %b", obs, 8'b1000_1100);
        end
        pulse_ack();
        checks++;
        if (obs !== 8'b0010_0100) begin
            errors++; $display("FAIL nmi_keeps_iff2: got %b want %b", obs, 8'b0010_0100);
        end
        pulse_retn();
        checks++;
        if (obs !== 8'b0010_1100) begin
            errors++; $display("FAIL retn: got %b want %b", obs, 8'b0010_1100);
        end
        pulse_done();
    endtask

    task automatic test_nmi_priority();
        intr = 1; nmi_pulse(2); bnd_tick();
        checks++;
        if (obs !== 8'b1000_1100) begin
            errors++; $display("FAIL nmi_over_int: got %b want %b", obs, 8'b1000_1100);
        end
        pulse_ack(); pulse_retn(); pulse_done();
        bnd_tick();
        checks++;
        if (obs !== 8'b0100_1100) begin
            errors++; $display("FAIL int_after_nmi: got %b want %b", obs, 8'b0100_1100);
        end
        pulse_ack(); intr = 0;
        nmi_pulse(2); bnd_tick();
        checks++;
        if (obs !== 8'b0001_0000) begin
            errors++; $display("FAIL nmi_held_in_svc: got %b want %b", obs, 8'b0001_0000);
        end
        pulse_done(); bnd_tick();
        checks++;
        if (obs !== 8'b1000_0000) begin
            errors++; $display("FAIL nmi_after_svc: got %b want %b", obs, 8'b1000_0000);
        end
        pulse_ack(); pulse_done();
    endtask

    task automatic test_im();
        bit [1:0] want [3] = '{2'd2, 2'd1, 2'd0};
        bit [1:0] src  [3] = '{2'd3, 2'd1, 2'd0};
        for (int i = 0; i < 3; i++) begin
            im_in = src[i]; ctl_im_we = 1; tick(); ctl_im_we = 0;
            checks++;
            if (obs !== {6'b0, want[i]}) begin
                errors++; $display("FAIL im_write %0d: got %b want %b", i, obs, {6'b0, want[i]});
            end
        end
    endtask

    task automatic test_filter();
        logic [7:0] want;
`ifdef NMI_GLITCH_FILTER_EN
        want = 8'b0000_0000;
`else
        want = 8'b1000_0000;
`endif
        nmi = 1; tick(); nmi = 0;
        repeat (3) tick();
        bnd_tick();
        checks++;
        if (obs !== want) begin
            errors++; $display("FAIL nmi_1clk_pulse: got %b want %b", obs, want);
        end
        if (nmi_req) begin pulse_ack(); pulse_done(); end
        nmi_pulse(2); bnd_tick();
        checks++;
        if (obs !== 8'b1000_0000) begin
            errors++; $display("FAIL nmi_2clk_pulse: got %b want %b", obs, 8'b1000_0000);
        end
        pulse_ack(); pulse_done();
    endtask

    task automatic test_reset_svc();
        im_in = 2'd2; ctl_im_we = 1; tick(); ctl_im_we = 0;
        nmi_pulse(2); bnd_tick(); pulse_ack();
        checks++;
        if (obs !== 8'b0010_0010) begin
            errors++; $display("FAIL nmi_svc_pre_reset: got %b want %b", obs, 8'b0010_0010);
        end
        nmi_pulse(2);
        nreset = 0; tick();
        checks++;
        if (obs !== 8'b0000_0000) begin
            errors++; $display("FAIL reset_in_svc: got %b want %b", obs, 8'b0000_0000);
        end
        nreset = 1; tick(); bnd_tick();
        checks++;
        if (obs !== 8'b0000_0000) begin
            errors++; $display("FAIL stale_nmi: got %b want %b", obs, 8'b0000_0000);
        end
    endtask

    task automatic test_random();
        logic [7:0] want;
        nreset = 0; tick(); nreset = 1;
        for (int i = 0; i < 3000; i++) begin
            nreset    = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 5) == 0) nmi = ~nmi;
            if ($urandom_range(0, 7) == 0) intr = ~intr;
            T_last    = ($urandom_range(0, 2) == 0);
            instr_end = ($urandom_range(0, 1) == 0);
            ctl_ei    = ($urandom_range(0, 11) == 0);
            ctl_di    = ($urandom_range(0, 15) == 0);
            ctl_retn  = ($urandom_range(0, 15) == 0);
            ctl_im_we = ($urandom_range(0, 19) == 0);
            im_in     = 2'($urandom_range(0, 3));
            ack       = ($urandom_range(0, 2) == 0);
            svc_done  = ($urandom_range(0, 3) == 0);
            tick();
            want = {m_phase == 1, m_phase == 2, m_phase == 3, m_phase == 4, m_iff1, m_iff2, m_im};
            checks++;
            if (obs !== want) begin
                errors++; $display("FAIL random cycle %0d: got %b want %b", i, obs, want);
            end
        end
        nreset = 1; nmi = 0; intr = 0; T_last = 0; instr_end = 0; ctl_ei = 0; ctl_di = 0;
        ctl_retn = 0; ctl_im_we = 0; ack = 0; svc_done = 0;
    endtask

    initial begin
        test_reset();
        test_ei_int();
        test_nmi_di();
        test_nmi_priority();
        test_im();
        test_filter();
        test_reset_svc();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
